feedback_pulser: RTL
====================

# feedback_pulser

Output-side companion to the button debouncer: turns single-cycle event strobes from game logic (reveal, flag, mine hit, win) into human-visible LED/buzzer pulse trains of programmable length and repeat count. Sits between the game controller and the board LED/buzzer pins. Holds one pending request while a sequence plays and reports dropped requests.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles per timing tick (1 ms at 50 MHz); must be ≥ 2.
- ON_TICKS, 100: ticks the output is high per blink; must be ≥ 1.
- OFF_TICKS, 100: ticks the output is low after each blink, including the last one; must be ≥ 1.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle request strobe; a multi-cycle high is one request per high cycle.
- count  in  4  blinks requested, sampled with trigger; 0 is treated as 1.
- clear_ovf  in  1  clears overflow.
- pulse_out  out  1  registered LED/buzzer drive.
- busy  out  1  registered; high while a sequence is playing.
- done  out  1  registered; one-cycle strobe at the end of each sequence.
- overflow  out  1  registered, sticky; a request was dropped.

## Operation
- FSM states: IDLE, ON, OFF. The registers are the state, a tick prescaler (0..TICK_DIV-1), a phase tick counter, a remaining-blink counter, and a pending slot (valid + 4-bit count).
- IDLE: on trigger, load the remaining count (count, or 1 if count is 0) and go to ON. Clear the prescaler and tick counter on every phase entry.
- ON: pulse_out=1. After ON_TICKS ticks, go to OFF.
- OFF: pulse_out=0. After OFF_TICKS ticks, decrement the remaining count.
  - If remaining > 0, go to ON.
  - Otherwise, assert done for one cycle. Then go to ON with the pending count if pending is valid (clear pending), else go to IDLE.
- busy = (state != IDLE). busy stays high across a back-to-back pending start.
- Trigger while busy:
  - If pending is empty, store it in pending.
  - If pending is full, drop it and set overflow.
- Trigger in the sequence-end (done) cycle with pending empty: start it directly as the next sequence, the same as a pending start.
- Trigger in the sequence-end cycle with pending full: start the pending request, store the new request in pending, and do not set overflow.
- clear_ovf and a new overflow in the same cycle: overflow ends at 1 (set wins).
- Counter widths are sized by $clog2 of the parameters. No counter wraps; each one is reset on phase entry.

## Timing
- Reset (asynchronous, on resetn low): pulse_out=0, busy=0, done=0, overflow=0, pending cleared, state=IDLE. Reset mid-sequence drops pulse_out immediately, without waiting for a clock edge.
- Latency: trigger sampled at edge t (IDLE) → pulse_out and busy are high after edge t.
- ON phase: exactly ON_TICKS×TICK_DIV cycles of pulse_out=1.
- OFF phase: exactly OFF_TICKS×TICK_DIV cycles of pulse_out=0.
- A sequence of N blinks occupies N×(ON_TICKS+OFF_TICKS)×TICK_DIV cycles of busy=1.
- done rises in the last cycle of the final OFF phase.
- Pending start: pulse_out rises in the cycle after done. busy has no gap.

## Test plan
Use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3 (ON = 8 cycles, OFF = 12 cycles) for all scenarios.
1. Reset during ON: resetn low → pulse_out, busy, done, overflow all 0 without waiting for a clock edge. After release, idle holds pulse_out=0 indefinitely.
2. Single blink: trigger with count=1 → pulse_out high 8 cycles then low 12 cycles. busy high 20 cycles, done high on cycle 20 only.
3. count=0 behaves as count=1. count=3 → three 8-high/12-low blinks, busy 60 cycles, exactly one done.
4. Pending: count=2, then a trigger with count=1 at cycle 5 → after done (cycle 40), pulse_out rises at cycle 41, busy unbroken, total 60 cycles, two done strobes, overflow=0.
5. Overflow: three triggers during one sequence → third dropped, overflow=1 and stays 1. clear_ovf → 0. clear_ovf with a simultaneous drop → 1.
6. Trigger exactly on the done cycle, pending empty → next sequence starts the following cycle with no IDLE cycle. With pending full → pending starts, new request is queued, overflow=0.

Source files
------------

// File: rtl/feedback_pulser.sv
// Turns single-cycle event strobes into visible LED/buzzer blink trains.
// While a train plays it holds one pending request and flags any request it has to drop.
module feedback_pulser #(
    parameter int TICK_DIV  = 50000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       trigger,
    input  logic [3:0] count,
    input  logic       clear_ovf,
    output logic       pulse_out,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [TW-1:0] ticks, ticks_nx;
    logic [3:0]    remain, remain_nx;
    logic          pend_valid, pend_valid_nx;
    logic [3:0]    pend_cnt, pend_cnt_nx;
    logic          pulse_nx, busy_nx, done_nx, overflow_nx;
    logic          ovf_set;
    logic          tick, on_end, off_end, seq_end;
    logic [3:0]    req_cnt;

    assign req_cnt = (count == 4'd0) ? 4'd1 : count;
    assign tick    = (presc == PRESC_LAST);
    assign on_end  = (state == ON)  && tick && (ticks == ON_LAST);
    assign off_end = (state == OFF) && tick && (ticks == OFF_LAST);
    assign seq_end = off_end && (remain == 4'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            remain     <= '0;
            pend_valid <= 1'b0;
            pend_cnt   <= '0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            ticks      <= ticks_nx;
            remain     <= remain_nx;
            pend_valid <= pend_valid_nx;
            pend_cnt   <= pend_cnt_nx;
            pulse_out  <= pulse_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            overflow   <= overflow_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        presc_nx      = presc + 1'b1;
        ticks_nx      = ticks;
        remain_nx     = remain;
        pend_valid_nx = pend_valid;
        pend_cnt_nx   = pend_cnt;
        ovf_set       = 1'b0;

        if (tick) begin
            presc_nx = '0;
            ticks_nx = ticks + 1'b1;
        end

        case (state)
            IDLE: begin
                presc_nx = '0;
                ticks_nx = '0;
                if (trigger) begin
                    state_nx  = ON;
                    remain_nx = req_cnt;
                end
            end
            ON: begin
                if (on_end) begin
                    state_nx = OFF;
                    presc_nx = '0;
                    ticks_nx = '0;
                end
            end
            OFF: begin
                if (off_end) begin
                    presc_nx  = '0;
                    ticks_nx  = '0;
                    remain_nx = remain - 4'd1;
                    if (remain != 4'd1) begin
                        state_nx = ON;
                    end else if (pend_valid) begin
                        // The pending request starts and a same-cycle trigger refills the slot.
                        state_nx      = ON;
                        remain_nx     = pend_cnt;
                        pend_valid_nx = trigger;
                        if (trigger) begin
                            pend_cnt_nx = req_cnt;
                        end
                    end else if (trigger) begin
                        state_nx  = ON;
                        remain_nx = req_cnt;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (trigger && (state != IDLE) && !seq_end) begin
            if (!pend_valid) begin
                pend_valid_nx = 1'b1;
                pend_cnt_nx   = req_cnt;
            end else begin
                ovf_set = 1'b1;
            end
        end

        overflow_nx = ovf_set | (overflow & ~clear_ovf);
        pulse_nx    = (state_nx == ON);
        busy_nx     = (state_nx != IDLE);
        // Flag the final OFF cycle one edge early so the registered strobe lands on it.
        done_nx     = (state_nx == OFF) && (presc_nx == PRESC_LAST) &&
                      (ticks_nx == OFF_LAST) && (remain_nx == 4'd1);
    end

endmodule
